// File: rtl/dcache_pkg.sv
// Shared address-field widths, line geometry and controller state encoding for the data cache.
package dcache_pkg;

  localparam int unsigned TAG_W     = 23;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned OFS_W     = 5;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WSEL_W    = OFS_W - 2;
  localparam int unsigned LINE_BITS = 256;

  typedef enum logic [1:0] {
    StIdle,
    StWb,
    StFill,
    StDone
  } dc_state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port on the clock edge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NumLines = 16,
  parameter int unsigned LineBits = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [LineBits-1:0] rd_line_o,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic                wr_valid_i,
  input  logic                wr_dirty_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [LineBits-1:0] wr_line_i
);

  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [LineBits-1:0] data_q [NumLines];

  // Only the status bits are reset; tags and data are don't-care while invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 MemStall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  import dcache_pkg::*;

  dc_state_e state_q, state_d;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WSEL_W-1:0]    req_word;
  logic                 access;
  logic                 hit;
  logic                 stall;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0] merged_line;
  logic                 we;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_line;
  logic                 unused_byte_ofs;

  assign req_tag         = addr_i[31 -: TAG_W];
  assign req_idx         = addr_i[OFS_W +: IDX_W];
  assign req_word        = addr_i[2 +: WSEL_W];
  assign unused_byte_ofs = ^addr_i[1:0];

  assign access = MemRead_i | MemWrite_i;
  assign hit    = rd_valid && (rd_tag == req_tag);

  always_comb begin
    merged_line = rd_line;
    merged_line[int'(req_word) * WORD_W +: WORD_W] = data_i;
  end

  // The array word is always presented; the pipeline only consumes it on an IDLE hit.
  assign data_o = rd_line[int'(req_word) * WORD_W +: WORD_W];

  dcache_sram #(
    .NumLines(NUM_LINES),
    .LineBits(LINE_BITS)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_ni    (rst_i),
    .rd_idx_i  (req_idx),
    .rd_valid_o(rd_valid),
    .rd_dirty_o(rd_dirty),
    .rd_tag_o  (rd_tag),
    .rd_line_o (rd_line),
    .we_i      (we),
    .wr_idx_i  (req_idx),
    .wr_valid_i(1'b1),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i  (req_tag),
    .wr_line_i (wr_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = {req_tag, req_idx, {OFS_W{1'b0}}};
    mem_data_o  = rd_line;
    we          = 1'b0;
    wr_dirty    = 1'b1;
    wr_line     = merged_line;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (hit) begin
            // A simultaneous read+write is a store.
            we = MemWrite_i;
          end else begin
            stall   = 1'b1;
            state_d = (rd_valid && rd_dirty) ? StWb : StFill;
          end
        end
      end
      StWb: begin
        stall       = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {rd_tag, req_idx, {OFS_W{1'b0}}};
        if (mem_ack_i) begin
          state_d = StFill;
        end
      end
      StFill: begin
        stall     = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          we       = 1'b1;
          wr_dirty = 1'b0;
          wr_line  = mem_data_i;
          state_d  = StDone;
        end
      end
      StDone: begin
        stall   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A miss decoded during reset must not stall the pipeline.
  assign MemStall_o = stall & rst_i;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed table-driven bench for dcache_ctrl with a behavioural main-memory responder.
module tb_dcache_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic         MemRead_i;
  logic         MemWrite_i;
  logic [31:0]  addr_i;
  logic [31:0]  data_i;
  logic [31:0]  data_o;
  logic         MemStall_o;
  logic         mem_req_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl #(
    .NUM_LINES(16),
    .LINE_BITS(256)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .MemStall_o (MemStall_o),
    .mem_req_o  (mem_req_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_txn;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic [31:0] exp_w1;
  } vec_t;

  localparam int NV = 13;

  vec_t         vecs [NV];
  logic [255:0] mem_arr [1024];
  logic         txn_w [4];
  logic [31:0]  txn_a [4];
  logic [255:0] txn_d [4];
  int           n_txn;
  int           checks;
  int           errors;
  int           cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", name, cur, act, exp);
    end
  endtask

  // Drives one access until the cycle where MemStall_o drops, playing main memory meanwhile.
  task automatic run_access(input vec_t v, output int stalls, output logic [31:0] dout,
                            output logic tmo);
    int          cnt;
    logic [31:0] a_first;
    MemRead_i  = v.rd;
    MemWrite_i = v.wr;
    addr_i     = v.addr;
    data_i     = v.wdata;
    n_txn      = 0;
    cnt        = 0;
    stalls     = 0;
    dout       = '0;
    a_first    = '0;
    tmo        = 1'b1;
    for (int c = 0; c < 64 && tmo; c++) begin
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        cnt++;
        if (cnt == 1) a_first = mem_addr_o;
        else chk("req_addr_stable", mem_addr_o, a_first);
        if (!mem_write_o) mem_data_i = mem_arr[mem_addr_o[14:5]];
        if (cnt == v.lat) begin
          mem_ack_i = 1'b1;
          if (n_txn < 4) begin
            txn_w[n_txn] = mem_write_o;
            txn_a[n_txn] = mem_addr_o;
            txn_d[n_txn] = mem_data_o;
          end
          n_txn++;
          if (mem_write_o) mem_arr[mem_addr_o[14:5]] = mem_data_o;
          cnt = 0;
        end
      end
      #1;
      if (!MemStall_o) begin
        dout = data_o;
        tmo  = 1'b0;
      end else begin
        stalls++;
      end
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
    end
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    int          stalls;
    logic [31:0] dout;
    logic        tmo;
    run_access(v, stalls, dout, tmo);
    chk("timeout", {31'b0, tmo}, 32'd0);
    chk("stall_cycles", stalls, v.exp_stall);
    if (v.chk_data) chk("load_data", dout, v.exp_data);
    chk("txn_count", n_txn, v.exp_txn);
    if (v.exp_txn == 2) begin
      chk("wb_is_write", {31'b0, txn_w[0]}, 32'd1);
      chk("wb_addr", txn_a[0], v.exp_a0);
      chk("wb_word1", txn_d[0][63:32], v.exp_w1);
      chk("fill_is_read", {31'b0, txn_w[1]}, 32'd0);
      chk("fill_addr", txn_a[1], v.exp_a1);
    end else if (v.exp_txn == 1) begin
      chk("fill_is_read", {31'b0, txn_w[0]}, 32'd0);
      chk("fill_addr", txn_a[0], v.exp_a0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    checks = 0;
    errors = 0;
    cur    = -1;

    // Memory word i of line k holds {k, i}; line 2 word 0 carries the cold-miss marker.
    for (int k = 0; k < 1024; k++) begin
      for (int i = 0; i < 8; i++) mem_arr[k][i*32 +: 32] = {16'(k), 16'(i)};
    end
    mem_arr[2][31:0] = 32'hDEAD_BEEF;

    //          rd    wr    addr          wdata         lat st chk  data          txn a0          a1            w1
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 5, 1'b1, 32'hDEAD_BEEF, 1, 32'h0000_0040, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 3, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0,         32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         3, 0, 1'b1, 32'h1234_5678, 0, 32'h0,         32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0240, 32'h0,         3, 8, 1'b1, 32'h0012_0000, 2, 32'h0000_0040, 32'h0000_0240, 32'h1234_5678};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         3, 5, 1'b1, 32'h1234_5678, 1, 32'h0000_0040, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0380, 32'hA5A5_A5A5, 3, 5, 1'b0, 32'h0,         1, 32'h0000_0380, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0380, 32'h0,         3, 0, 1'b1, 32'hA5A5_A5A5, 0, 32'h0,         32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0384, 32'h0,         3, 0, 1'b1, 32'h001C_0001, 0, 32'h0,         32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0180, 32'h0,         1, 4, 1'b1, 32'h000C_0000, 2, 32'h0000_0380, 32'h0000_0180, 32'h001C_0001};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0184, 32'hCAFE_F00D, 1, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0,         32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0184, 32'h0,         1, 0, 1'b1, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         2, 4, 1'b1, 32'h0000_0002, 1, 32'h0000_0000, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0,         32'h0};

    // Reset with a load pending: no stall, no memory request.
    rst_i      = 1'b0;
    MemRead_i  = 1'b1;
    MemWrite_i = 1'b0;
    addr_i     = 32'h0000_0040;
    data_i     = '0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_stall", {31'b0, MemStall_o}, 32'd0);
    chk("reset_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset_mem_write", {31'b0, mem_write_o}, 32'd0);
    MemRead_i = 1'b0;
    rst_i     = 1'b1;
    @(posedge clk_i);
    #1;

    // Spurious ack with no access pending.
    mem_ack_i = 1'b1;
    #1;
    chk("idle_ack_stall", {31'b0, MemStall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    #1;
    chk("idle_ack_req", {31'b0, mem_req_o}, 32'd0);
    chk("idle_ack_stall_after", {31'b0, MemStall_o}, 32'd0);

    for (int n = 0; n < NV; n++) begin
      cur = n;
      check_vec(vecs[n]);
    end
    cur = 100;
    chk("mem_victim_word0", mem_arr[28][31:0], 32'hA5A5_A5A5);

    // Reset in the middle of a fill.
    cur        = 200;
    MemRead_i  = 1'b1;
    addr_i     = 32'h0000_02C0;
    #1;
    chk("miss_comb_stall", {31'b0, MemStall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    chk("fill_req", {31'b0, mem_req_o}, 32'd1);
    chk("fill_write", {31'b0, mem_write_o}, 32'd0);
    chk("fill_addr_early", mem_addr_o, 32'h0000_02C0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("rst_stall_drop", {31'b0, MemStall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    MemRead_i = 1'b0;
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    #1;
    chk("stray_ack_req", {31'b0, mem_req_o}, 32'd0);
    chk("stray_ack_stall", {31'b0, MemStall_o}, 32'd0);

    cur = 201;
    hv  = '{1'b1, 1'b0, 32'h0000_02C0, 32'h0, 3, 5, 1'b1, 32'h0016_0000, 1, 32'h0000_02C0,
            32'h0, 32'h0};
    check_vec(hv);
    // Reset also invalidated line 2, so a previously resident address misses cleanly.
    cur = 202;
    hv  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 4, 1'b1, 32'h1234_5678, 1, 32'h0000_0040,
            32'h0, 32'h0};
    check_vec(hv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
